wb_arbiter: RTL

Writeback arbiter that owns the single write port of the pipelined RISC-V register file. It merges in-order pipeline writebacks with out-of-order results from a long-latency unit (multiplier/divider) through a small result FIFO. It also keeps a pending-destination scoreboard that decode uses to detect hazards. Outputs are registered on the rising edge so that they are stable when the register file writes on the falling edge.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/wb_fifo.sv | 47 ++++
 rtl/wb_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V widths and the writeback request record used by the arbiter.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_ENTRY_W = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: pipeline writebacks first, then queued
// long-latency results, plus the pending-destination scoreboard for decode.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  ll_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  stall_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] a3_o,
  output logic [XLEN-1:0]       wd3_o
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int NREGS = 1 << REG_ADDR_W;
  localparam logic [AGE_W-1:0] AGE_ONE = 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [WB_ENTRY_W-1:0] fifo_dout;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;

  wb_req_t               sel_req;
  logic                  sel_pipe, sel_ll;
  logic [NREGS-1:0]      busy_q, busy_d, set_mask, clr_mask;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  age_expired;

  assign ll_ready  = (fifo_count < CW'(DEPTH));
  assign fifo_push = ll_valid && ll_ready;
  assign fifo_pop  = sel_ll;
  assign head_rd   = fifo_dout[WB_ENTRY_W-1 -: REG_ADDR_W];
  assign head_data = fifo_dout[XLEN-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({ll_rd, ll_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // An x0 head is still popped; it simply produces no write.
  always_comb begin
    sel_pipe = wb_valid && (wb_rd != '0);
    sel_ll   = !sel_pipe && !fifo_empty;
    sel_req  = '0;
    clr_mask = '0;
    set_mask = '0;
    if (sel_pipe) begin
      sel_req.valid = 1'b1;
      sel_req.rd    = wb_rd;
      sel_req.data  = wb_data;
    end else if (sel_ll && (head_rd != '0)) begin
      sel_req.valid     = 1'b1;
      sel_req.rd        = head_rd;
      sel_req.data      = head_data;
      clr_mask[head_rd] = 1'b1;
    end
    if (iss_valid && (iss_rd != '0)) set_mask[iss_rd] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    age_expired = (age_q >= AGE_MAX);
    age_d       = age_q;
    if (fifo_empty || fifo_pop) age_d = '0;
    else if (!age_expired)      age_d = age_q + AGE_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      a3_o    <= '0;
      wd3_o   <= '0;
      stall_o <= 1'b0;
      busy_q  <= '0;
      age_q   <= '0;
    end else begin
      we_o    <= sel_req.valid;
      a3_o    <= sel_req.rd;
      wd3_o   <= sel_req.data;
      stall_o <= age_expired || fifo_full;
      busy_q  <= busy_d;
      age_q   <= age_d;
    end
  end

  assign q_busy1 = busy_q[q_rs1];
  assign q_busy2 = busy_q[q_rs2];

  // Decode must never let a pipeline write target a register still owed a result.
  waw_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && (wb_rd != '0) && busy_q[wb_rd]));

endmodule
